// File: rtl/sat_loader_pkg.sv
// Shared types and helpers for the sat_engine loader: FSM state encoding,
// clause-index width and one-hot strobe generation.
package sat_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStates,
        StStart,
        StWait,
        StUnload,
        StFin
    } loader_state_e;

    // Widest clause strobe the helpers support; callers cast down to NUM_CLAUSES.
    localparam int unsigned MaxClauses = 64;

    typedef logic [MaxClauses-1:0] onehot_t;

    function automatic int unsigned clause_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic onehot_t onehot(input int unsigned idx);
        onehot_t v;
        v = onehot_t'(1) << idx;
        return v;
    endfunction

endpackage

// File: rtl/sat_engine_loader.sv
// Load/start/unload sequencer for one sat_engine bin.
// Define SAT_LOADER_SKIP_EMPTY_EN to suppress write-back of all-zero clauses.
module sat_engine_loader
    import sat_loader_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES  = 8,
    parameter int unsigned NUM_VARS     = 8,
    parameter int unsigned NUM_LVLS     = 8,
    parameter int unsigned WIDTH_BIN_ID = 15
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start_i,
    input  logic [WIDTH_BIN_ID-1:0]                        bin_num_i,
    output logic                                           done_o,
    output logic                                           cmem_rd_o,
    output logic                                           cmem_wr_o,
    output logic [WIDTH_BIN_ID+clause_bits(NUM_CLAUSES)-1:0] cmem_addr_o,
    output logic [2*NUM_VARS-1:0]                          cmem_wdata_o,
    input  logic [2*NUM_VARS-1:0]                          cmem_rdata_i,
    output logic [NUM_CLAUSES-1:0]                         eng_wr_carray_o,
    output logic [2*NUM_VARS-1:0]                          eng_clause_o,
    output logic [NUM_VARS-1:0]                            eng_wr_var_states_o,
    output logic [NUM_LVLS-1:0]                            eng_wr_lvl_states_o,
    output logic                                           eng_start_o,
    output logic                                           eng_base_lvl_en_o,
    input  logic                                           eng_done_i,
    output logic [NUM_CLAUSES-1:0]                         eng_rd_carray_o,
    input  logic [2*NUM_VARS-1:0]                          eng_clause_i
);

    localparam int unsigned CB   = clause_bits(NUM_CLAUSES);
    localparam int unsigned AW   = WIDTH_BIN_ID + CB;
    localparam int unsigned CntW = CB + 1;

    localparam logic [CB:0] CntLast = CntW'(NUM_CLAUSES);
    localparam logic [CB:0] CntOne  = CntW'(1);

    loader_state_e           state_q;
    logic [CB:0]             cnt_q;
    logic [CB:0]             cnt_inc;
    logic [WIDTH_BIN_ID-1:0] bin_q;

    logic                    cmem_rd_q;
    logic                    cmem_wr_q;
    logic [AW-1:0]           cmem_addr_q;
    logic [NUM_CLAUSES-1:0]  wr_carray_q;
    logic [NUM_CLAUSES-1:0]  rd_carray_q;
    logic [NUM_VARS-1:0]     var_states_q;
    logic [NUM_LVLS-1:0]     lvl_states_q;
    logic                    eng_start_q;
    logic                    base_lvl_en_q;
    logic                    done_q;

    assign cnt_inc = cnt_q + CntOne;

    // Read issue for index k+1 and engine write for index k share a cycle in
    // LOAD; UNLOAD mirrors this with engine read and memory write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bin_q         <= '0;
            cmem_rd_q     <= 1'b0;
            cmem_wr_q     <= 1'b0;
            cmem_addr_q   <= '0;
            wr_carray_q   <= '0;
            rd_carray_q   <= '0;
            var_states_q  <= '0;
            lvl_states_q  <= '0;
            eng_start_q   <= 1'b0;
            base_lvl_en_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            cmem_rd_q     <= 1'b0;
            cmem_wr_q     <= 1'b0;
            wr_carray_q   <= '0;
            rd_carray_q   <= '0;
            var_states_q  <= '0;
            lvl_states_q  <= '0;
            eng_start_q   <= 1'b0;
            base_lvl_en_q <= 1'b0;
            done_q        <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        bin_q       <= bin_num_i;
                        cnt_q       <= '0;
                        cmem_rd_q   <= 1'b1;
                        cmem_addr_q <= {bin_num_i, {CB{1'b0}}};
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (cnt_q == CntLast) begin
                        cnt_q        <= '0;
                        var_states_q <= '1;
                        lvl_states_q <= '1;
                        state_q      <= StStates;
                    end else begin
                        wr_carray_q <= NUM_CLAUSES'(onehot(32'(cnt_q)));
                        if (cnt_inc != CntLast) begin
                            cmem_rd_q   <= 1'b1;
                            cmem_addr_q <= {bin_q, cnt_inc[CB-1:0]};
                        end
                        cnt_q <= cnt_inc;
                    end
                end
                StStates: begin
                    eng_start_q   <= 1'b1;
                    base_lvl_en_q <= 1'b1;
                    state_q       <= StStart;
                end
                StStart: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (eng_done_i) begin
                        rd_carray_q <= NUM_CLAUSES'(onehot(0));
                        cnt_q       <= '0;
                        state_q     <= StUnload;
                    end
                end
                StUnload: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        cmem_wr_q   <= 1'b1;
                        cmem_addr_q <= {bin_q, cnt_q[CB-1:0]};
                        if (cnt_inc != CntLast) begin
                            rd_carray_q <= NUM_CLAUSES'(onehot(32'(cnt_inc)));
                        end
                        cnt_q <= cnt_inc;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef SAT_LOADER_SKIP_EMPTY_EN
    assign cmem_wr_o = cmem_wr_q & (|eng_clause_i);
`else
    assign cmem_wr_o = cmem_wr_q;
`endif

    // Data buses pass straight through but read zero outside their strobe.
    assign cmem_wdata_o        = cmem_wr_q ? eng_clause_i : '0;
    assign eng_clause_o        = (|wr_carray_q) ? cmem_rdata_i : '0;
    assign cmem_rd_o           = cmem_rd_q;
    assign cmem_addr_o         = cmem_addr_q;
    assign eng_wr_carray_o     = wr_carray_q;
    assign eng_rd_carray_o     = rd_carray_q;
    assign eng_wr_var_states_o = var_states_q;
    assign eng_wr_lvl_states_o = lvl_states_q;
    assign eng_start_o         = eng_start_q;
    assign eng_base_lvl_en_o   = base_lvl_en_q;
    assign done_o              = done_q;

endmodule

// File: tb/tb_sat_engine_loader.sv
// Bench for sat_engine_loader: table of full load/start/unload flows checked
// through a read/write scoreboard, plus abort-by-reset and idle-ignore sequences.
module tb_sat_engine_loader;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WB = 15;
    localparam int CW = 2 * NV;
    localparam int AW = WB + 3;

`ifdef SAT_LOADER_SKIP_EMPTY_EN
    localparam bit SkipEn = 1'b1;
`else
    localparam bit SkipEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [WB-1:0] bin_num_i = '0;
    logic          done_o;
    logic          cmem_rd_o;
    logic          cmem_wr_o;
    logic [AW-1:0] cmem_addr_o;
    logic [CW-1:0] cmem_wdata_o;
    logic [CW-1:0] cmem_rdata_i = '0;
    logic [NC-1:0] eng_wr_carray_o;
    logic [CW-1:0] eng_clause_o;
    logic [NV-1:0] eng_wr_var_states_o;
    logic [NL-1:0] eng_wr_lvl_states_o;
    logic          eng_start_o;
    logic          eng_base_lvl_en_o;
    logic          eng_done_i = 1'b0;
    logic [NC-1:0] eng_rd_carray_o;
    logic [CW-1:0] eng_clause_i = '0;

    sat_engine_loader #(
        .NUM_CLAUSES (NC),
        .NUM_VARS    (NV),
        .NUM_LVLS    (NL),
        .WIDTH_BIN_ID(WB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start_i),
        .bin_num_i          (bin_num_i),
        .done_o             (done_o),
        .cmem_rd_o          (cmem_rd_o),
        .cmem_wr_o          (cmem_wr_o),
        .cmem_addr_o        (cmem_addr_o),
        .cmem_wdata_o       (cmem_wdata_o),
        .cmem_rdata_i       (cmem_rdata_i),
        .eng_wr_carray_o    (eng_wr_carray_o),
        .eng_clause_o       (eng_clause_o),
        .eng_wr_var_states_o(eng_wr_var_states_o),
        .eng_wr_lvl_states_o(eng_wr_lvl_states_o),
        .eng_start_o        (eng_start_o),
        .eng_base_lvl_en_o  (eng_base_lvl_en_o),
        .eng_done_i         (eng_done_i),
        .eng_rd_carray_o    (eng_rd_carray_o),
        .eng_clause_i       (eng_clause_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            idx;
        logic [CW-1:0] data;
        int            cyc;
    } pend_t;

    typedef struct {
        logic [WB-1:0] bin;
        int            wait_cyc;
        logic [NC-1:0] zero_mask;
        bit            inject;
        int            exp_wr;
    } vec_t;

    pend_t         ld_q[$];
    pend_t         ul_q[$];
    logic [WB-1:0] exp_bin = '0;
    int            ld_k, ul_k, wr_cnt, done_cnt, states_cyc, ld_first_cyc;
    bit            mon_en = 1'b0;
    logic [CW-1:0] eng_ret[NC];

    function automatic logic [CW-1:0] mem_f(input logic [AW-1:0] a);
        return 16'(a * 37 + 5) ^ 16'h5a00;
    endfunction

    function automatic logic [NC-1:0] oh(input int i);
        logic [NC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Clause memory with 1-cycle read latency; engine returns eng_ret[k] after rd strobe k.
    always @(posedge clk) if (cmem_rd_o) cmem_rdata_i <= mem_f(cmem_addr_o);

    always @(posedge clk) begin
        for (int j = 0; j < NC; j++) begin
            if (eng_rd_carray_o[j]) eng_clause_i <= eng_ret[j];
        end
    end

    // Scoreboard: reads push the expected engine write / memory write-back,
    // which must appear exactly one cycle later.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("rd_wr_overlap", cmem_rd_o & cmem_wr_o, 0);
                if (ld_q.size() > 0 && ld_q[0].cyc == cyc - 1) begin
                    p = ld_q.pop_front();
                    chk("eng_wr_carray", eng_wr_carray_o, oh(p.idx));
                    chk("eng_clause_o", eng_clause_o, p.data);
                end else begin
                    chk("eng_wr_carray_idle", eng_wr_carray_o, 0);
                end
                if (cmem_rd_o) begin
                    if (ld_k == 0) ld_first_cyc = cyc;
                    chk("cmem_rd_addr", cmem_addr_o, {exp_bin, 3'(ld_k)});
                    ld_q.push_back('{ld_k, mem_f({exp_bin, 3'(ld_k)}), cyc});
                    ld_k++;
                end
                if (ul_q.size() > 0 && ul_q[0].cyc == cyc - 1) begin
                    p = ul_q.pop_front();
                    chk("cmem_wb_addr", cmem_addr_o, {exp_bin, 3'(p.idx)});
                    if (!SkipEn || p.data != 0) begin
                        chk("cmem_wr", cmem_wr_o, 1);
                        chk("cmem_wdata", cmem_wdata_o, p.data);
                    end else begin
                        chk("cmem_wr_skipped", cmem_wr_o, 0);
                    end
                end else begin
                    chk("cmem_wr_idle", cmem_wr_o, 0);
                end
                if (eng_rd_carray_o != 0) begin
                    chk("eng_rd_carray", eng_rd_carray_o, oh(ul_k % NC));
                    ul_q.push_back('{ul_k, eng_ret[ul_k % NC], cyc});
                    ul_k++;
                end
                if (cmem_wr_o) wr_cnt++;
                if (eng_wr_var_states_o != 0 || eng_wr_lvl_states_o != 0) begin
                    chk("var_states", eng_wr_var_states_o, {NV{1'b1}});
                    chk("lvl_states", eng_wr_lvl_states_o, {NL{1'b1}});
                    states_cyc = cyc;
                end
                chk("base_lvl_en", eng_base_lvl_en_o, eng_start_o);
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic run_flow(input logic [WB-1:0] bin, input int w, input logic [NC-1:0] zmask,
                            input bit inj, input int exp_wr, input int abort_k);
        int s0;
        bit ok;
        for (int j = 0; j < NC; j++) begin
            eng_ret[j] = zmask[j] ? 16'h0 : (16'h8000 | 16'(j << 4) | 16'(bin[3:0]));
        end
        exp_bin = bin;
        ld_k = 0; ul_k = 0; wr_cnt = 0; done_cnt = 0; states_cyc = -1; ld_first_cyc = -1;
        ld_q.delete();
        ul_q.delete();

        @(negedge clk);
        start_i   = 1'b1;
        bin_num_i = bin;
        s0        = cyc;
        ok        = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (eng_start_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("eng_start_seen", ok, 1);
        chk("eng_start_cyc", cyc, s0 + 11);
        chk("first_read_cyc", ld_first_cyc, s0 + 1);
        chk("states_cyc", states_cyc, s0 + 10);
        chk("load_reads", ld_k, NC);

        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (inj && i == 2) begin
                start_i   = 1'b1;
                bin_num_i = bin ^ 15'h5;
            end else begin
                start_i = 1'b0;
            end
        end
        eng_done_i = 1'b1;
        @(negedge clk);
        eng_done_i = 1'b0;
        start_i    = 1'b0;

        if (abort_k >= 0) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (eng_rd_carray_o == oh(abort_k)) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("abort_point_reached", ok, 1);
            rst = 1'b0;
            @(posedge clk);
            #1;
            ld_q.delete();
            ul_q.delete();
            chk("abort_ctrl_zero", {done_o, cmem_rd_o, cmem_wr_o, eng_start_o, eng_base_lvl_en_o}, 0);
            chk("abort_addr_data_zero", {cmem_addr_o, cmem_wdata_o, eng_clause_o}, 0);
            chk("abort_strobes_zero", {eng_wr_carray_o, eng_rd_carray_o, eng_wr_var_states_o,
                                       eng_wr_lvl_states_o}, 0);
            @(negedge clk);
            rst = 1'b1;
            repeat (30) @(negedge clk);
            chk("abort_no_done", done_cnt, 0);
            return;
        end

        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", ok, 1);
        chk("done_cyc", cyc, s0 + 21 + w);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_cnt, exp_wr);
        chk("unload_reads", ul_k, NC);
        chk("scoreboard_drained", ld_q.size() + ul_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{15'd3,      20, 8'h00,        1'b0, 8};
        vecs[1] = '{15'h7fff,   1,  8'h00,        1'b0, 8};
        vecs[2] = '{15'd3,      20, 8'h00,        1'b1, 8};
        vecs[3] = '{15'd100,    5,  8'b0010_0100, 1'b0, SkipEn ? 6 : 8};
        vecs[4] = '{15'h2aaa,   3,  8'hff,        1'b0, SkipEn ? 0 : 8};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {done_o, cmem_rd_o, cmem_wr_o, eng_start_o, eng_base_lvl_en_o}, 0);
        chk("reset_addr_data", {cmem_addr_o, cmem_wdata_o, eng_clause_o}, 0);
        chk("reset_strobes", {eng_wr_carray_o, eng_rd_carray_o, eng_wr_var_states_o,
                              eng_wr_lvl_states_o}, 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_flow(vecs[v].bin, vecs[v].wait_cyc, vecs[v].zero_mask, vecs[v].inject,
                     vecs[v].exp_wr, -1);
        end

        // Engine done while idle must not start an unload.
        @(negedge clk);
        eng_done_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_done_ignored", {eng_rd_carray_o, cmem_wr_o, done_o}, 0);
        end
        eng_done_i = 1'b0;

        run_flow(15'd9, 4, 8'h00, 1'b0, 8, 4);
        run_flow(15'd0, 20, 8'h00, 1'b0, 8, -1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
